// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweep checker.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    function automatic int cnt_w(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/tt_lut.sv
// Combinational truth-table bit select: bit_o = tbl[idx].
module tt_lut
    import tt_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [tt_w(N_IN)-1:0] tbl,
    input  logic [N_IN-1:0]       idx,
    output logic                  bit_o
);

    assign bit_o = tbl[idx];

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all input vectors into an external netlist and counts
// disagreements against a programmable truth table.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int                     N_IN     = 4,
    parameter int                     SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0]   TT_RESET = 16'h1AC6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [tt_w(N_IN)-1:0] cfg_tt,
    input  logic                  sweep_start,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_out,
    output logic [N_IN:0]         mis_count,
    output logic [N_IN-1:0]       first_mis,
    output logic [tt_w(N_IN)-1:0] tt_q
);

    localparam int TW = tt_w(N_IN);
    localparam int CW = cnt_w(SETTLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   mis_q, mis_d;
    logic [N_IN-1:0] first_q, first_d;
    logic [TW-1:0]   tbl_q, tbl_d;
    logic            rdy_q, busy_q, done_q;
    logic            exp_bit;

    tt_lut #(.N_IN(N_IN)) u_lut (
        .tbl   (tbl_q),
        .idx   (idx_q),
        .bit_o (exp_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        first_d = first_q;
        tbl_d   = tbl_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    tbl_d = cfg_tt;
                end
                if (sweep_start) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    mis_d   = '0;
                    first_d = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    if (dut_out != exp_bit) begin
                        mis_d = mis_q + (N_IN+1)'(1);
                        if (mis_q == '0) begin
                            first_d = idx_q;
                        end
                    end
                    // Index stays on the last vector so dut_in holds it afterwards
                    if (&idx_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mis_q   <= '0;
            first_q <= '0;
            tbl_q   <= TT_RESET;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            first_q <= first_d;
            tbl_q   <= tbl_d;
            rdy_q   <= (state_d == IDLE);
            busy_q  <= (state_d == DRIVE);
            done_q  <= (state_d == DONE);
        end
    end

    assign cfg_ready  = rdy_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign dut_in     = idx_q;
    assign mis_count  = mis_q;
    assign first_mis  = first_q;
    assign tt_q       = tbl_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench: table vectors, random sweeps, reset and busy corners.
module tb_tt_sweep_checker;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_tt;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic [4:0]  mis_count;
    logic [3:0]  first_mis;
    logic [15:0] tt_q;
    logic [15:0] model_tt;

    logic        cfg_valid3;
    logic        cfg_ready3;
    logic [7:0]  cfg_tt3;
    logic        sweep_start3;
    logic        sweep_busy3;
    logic        sweep_done3;
    logic [2:0]  dut_in3;
    logic        dut_out3;
    logic [3:0]  mis_count3;
    logic [2:0]  first_mis3;
    logic [7:0]  tt_q3;

    int checks = 0;
    int errors = 0;

    tt_sweep_checker dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_tt      (cfg_tt),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .mis_count   (mis_count),
        .first_mis   (first_mis),
        .tt_q        (tt_q)
    );

    tt_sweep_checker #(.N_IN(3), .SETTLE(1), .TT_RESET(8'h96)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid3),
        .cfg_ready   (cfg_ready3),
        .cfg_tt      (cfg_tt3),
        .sweep_start (sweep_start3),
        .sweep_busy  (sweep_busy3),
        .sweep_done  (sweep_done3),
        .dut_in      (dut_in3),
        .dut_out     (dut_out3),
        .mis_count   (mis_count3),
        .first_mis   (first_mis3),
        .tt_q        (tt_q3)
    );

    // Netlist stand-ins: arbitrary truth table, and 3-input parity
    assign dut_out  = model_tt[dut_in];
    assign dut_out3 = ^dut_in3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          ld;
        logic [15:0] ld_tt;
        logic [15:0] mdl;
        logic [4:0]  e_mis;
        logic [3:0]  e_first;
    } vec_t;

    vec_t vt[5];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic ref_eval(input logic [15:0] tt, input logic [15:0] mdl,
                            output logic [4:0] mis, output logic [3:0] first);
        mis = 0;
        first = 0;
        for (int i = 0; i < 16; i++) begin
            if (tt[i] != mdl[i]) begin
                if (mis == 0) first = 4'(i);
                mis++;
            end
        end
    endtask

    task automatic sweep4(input string nm, input bit ld, input logic [15:0] ld_tt,
                          input logic [15:0] mdl, input bit same,
                          output logic [4:0] mis_o, output logic [3:0] first_o);
        int n;
        bit seq_ok;
        model_tt = mdl;
        if (ld && !same) begin
            cfg_valid = 1'b1;
            cfg_tt = ld_tt;
            step;
            cfg_valid = 1'b0;
            check({nm, " tt_load"}, tt_q, ld_tt);
        end
        if (ld && same) begin
            cfg_valid = 1'b1;
            cfg_tt = ld_tt;
        end
        sweep_start = 1'b1;
        step;
        sweep_start = 1'b0;
        cfg_valid = 1'b0;
        if (ld && same) check({nm, " tt_same"}, tt_q, ld_tt);
        n = 1;
        seq_ok = 1'b1;
        while (!sweep_done && n < 100) begin
            if (dut_in != 4'((n - 1) / 2) || !sweep_busy || cfg_ready) seq_ok = 1'b0;
            step;
            n++;
        end
        check({nm, " done_cycle"}, n, 33);
        check({nm, " drive_seq"}, seq_ok, 1);
        mis_o = mis_count;
        first_o = first_mis;
        step;
        check({nm, " ready_after"}, {cfg_ready, sweep_busy, sweep_done}, 3'b100);
        check({nm, " mis_hold"}, mis_count, mis_o);
    endtask

    initial begin
        logic [4:0]  m, em;
        logic [3:0]  f, ef;
        logic [15:0] cur_tt, rtt, mask;
        int n, dones, done_at;
        bit quiet, same;

        vt[0] = '{"match",     1'b0, 16'h0000, 16'h1AC6,             5'd0,  4'd0};
        vt[1] = '{"inv_3_9",   1'b0, 16'h0000, 16'h1AC6 ^ 16'h0208,  5'd2,  4'd3};
        vt[2] = '{"inv_all",   1'b0, 16'h0000, ~16'h1AC6,            5'd16, 4'd0};
        vt[3] = '{"and4",      1'b1, 16'h8000, 16'h8000,             5'd0,  4'd0};
        vt[4] = '{"and4_zero", 1'b0, 16'h0000, 16'h0000,             5'd1,  4'd15};

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_tt = '0;
        sweep_start = 1'b0;
        model_tt = 16'h1AC6;
        cfg_valid3 = 1'b0;
        cfg_tt3 = '0;
        sweep_start3 = 1'b0;
        step;
        step;
        check("rst tt_q", tt_q, 16'h1AC6);
        check("rst flags", {cfg_ready, sweep_busy, sweep_done}, 3'b100);
        check("rst dut_in", dut_in, 0);
        check("rst results", {mis_count, first_mis}, 0);
        check("rst tt_q3", tt_q3, 8'h96);
        rst = 1'b0;
        step;

        for (int i = 0; i < 5; i++) begin
            sweep4(vt[i].name, vt[i].ld, vt[i].ld_tt, vt[i].mdl, 1'b0, m, f);
            check({vt[i].name, " mis"}, m, vt[i].e_mis);
            if (vt[i].e_mis != 0) check({vt[i].name, " first"}, f, vt[i].e_first);
        end
        cur_tt = 16'h8000;

        // Load attempt while busy is refused
        model_tt = 16'h8000;
        sweep_start = 1'b1;
        step;
        sweep_start = 1'b0;
        repeat (4) step;
        cfg_valid = 1'b1;
        cfg_tt = 16'hFFFF;
        check("busy cfg_ready", cfg_ready, 0);
        step;
        cfg_valid = 1'b0;
        check("busy tt_q", tt_q, 16'h8000);
        n = 0;
        while (!sweep_done && n < 100) begin
            step;
            n++;
        end
        check("busy done_seen", sweep_done, 1);
        check("busy mis", mis_count, 0);
        step;

        for (int i = 0; i < 12; i++) begin
            same = 1'($urandom_range(0, 1));
            rtt = 16'($urandom);
            mask = 16'($urandom & $urandom & $urandom);
            cur_tt = rtt;
            ref_eval(cur_tt, cur_tt ^ mask, em, ef);
            sweep4($sformatf("rand%0d", i), 1'b1, rtt, rtt ^ mask, same, m, f);
            check($sformatf("rand%0d mis", i), m, em);
            if (em != 0) check($sformatf("rand%0d first", i), f, ef);
        end

        // Reset in the middle of a sweep
        sweep4("pre_rst", 1'b1, 16'h1234, ~16'h1234, 1'b0, m, f);
        sweep_start = 1'b1;
        step;
        sweep_start = 1'b0;
        n = 0;
        while (dut_in != 4'd7 && n < 40) begin
            step;
            n++;
        end
        check("rst_mid reach7", dut_in, 7);
        check("rst_mid mis_nz", mis_count != 0, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("rst_mid tt_q", tt_q, 16'h1AC6);
        check("rst_mid flags", {cfg_ready, sweep_busy, sweep_done}, 3'b100);
        check("rst_mid results", {mis_count, first_mis, dut_in}, 0);
        quiet = 1'b1;
        repeat (40) begin
            step;
            if (sweep_done || sweep_busy) quiet = 1'b0;
        end
        check("rst_mid no_done", quiet, 1);
        sweep4("post_rst", 1'b0, 16'h0000, 16'h1AC6, 1'b0, m, f);
        check("post_rst mis", m, 0);

        // N_IN=3, SETTLE=1 parity sweep with a start while busy
        sweep_start3 = 1'b1;
        step;
        sweep_start3 = 1'b0;
        dones = 0;
        done_at = 0;
        for (int k = 1; k < 30; k++) begin
            if (sweep_done3) begin
                dones++;
                if (done_at == 0) done_at = k;
            end
            sweep_start3 = (k == 3);
            step;
        end
        sweep_start3 = 1'b0;
        check("par3 done_at", done_at, 9);
        check("par3 dones", dones, 1);
        check("par3 mis", mis_count3, 0);
        check("par3 dut_in", dut_in3, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
